debounce_multi: RTL



---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_tick_gen.sv | 38 +++
 rtl/debounce_multi.sv | 123 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and width helper for the debounce blocks
//
// Purpose : default divider/stability constants and a ceil(log2) helper used
//           to size counters in debounce_tick_gen and debounce_multi.
// Ports   : none (package).

package debounce_pkg;

    localparam int DEB_TICK_DIV_DEFAULT = 250000;
    localparam int DEB_STABLE_DEFAULT   = 4;
    localparam int DEB_LONG_DEFAULT     = 200;

    // Number of bits needed to hold values 0..value-1; never returns less
    // than 1 so that degenerate parameters still give a legal vector.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// rtl/debounce_tick_gen.sv - free-running divider producing a one-cycle sample tick
//
// Purpose : counts 0..TICK_DIV-1 and asserts tick for the single clk cycle in
//           which the count sits at TICK_DIV-1. Reusable by any slow-sampled logic.
// Ports   :
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (counter cleared to 0)
//   tick   out  one-clk sample strobe, period TICK_DIV cycles

module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEB_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CW   = clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Decoded from the count so the strobe lines up with the wrap cycle.
    assign tick = (count == LAST);

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel pushbutton debouncer with press/release pulses
//
// Purpose : per channel, synchronise a raw button, accept a new level only after
//           STABLE_TICKS consecutive sample ticks disagree with the current level,
//           and emit one-clk press/release pulses alongside the level change.
//           Optional long-press detection is built when DEBOUNCE_MULTI_LONG_PRESS_EN
//           is defined; otherwise pb_long is tied to 0.
// Ports   :
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   pb_in       in   [N_CH] raw asynchronous button inputs, active-high
//   pb_level    out  [N_CH] debounced level
//   pb_press    out  [N_CH] one-clk pulse on debounced 0->1
//   pb_release  out  [N_CH] one-clk pulse on debounced 1->0
//   pb_long     out  [N_CH] one-clk pulse after LONG_TICKS ticks of continuous high

module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = DEB_TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = DEB_STABLE_DEFAULT,
    parameter int LONG_TICKS   = DEB_LONG_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_press,
    output logic [N_CH-1:0] pb_release,
    output logic [N_CH-1:0] pb_long
);

    localparam int            SCW         = clog2(STABLE_TICKS + 1);
    localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_TICKS - 1);

    if (N_CH < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_param_check
        $error("debounce_multi: parameter out of range");
    end

    logic tick;

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]     sync_ff;
        logic [SCW-1:0] stable_cnt;
        logic           level_q;
        logic           press_q;
        logic           release_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_ff    <= '0;
                stable_cnt <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
            end else begin
                sync_ff   <= {sync_ff[0], pb_in[i]};
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (tick) begin
                    if (sync_ff[1] == level_q) begin
                        // Any sample matching the current level is a glitch
                        // boundary: the disagreement run starts over.
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        level_q    <= sync_ff[1];
                        stable_cnt <= '0;
                        press_q    <= sync_ff[1];
                        release_q  <= ~sync_ff[1];
                    end else begin
                        stable_cnt <= stable_cnt + SCW'(1);
                    end
                end
            end
        end

        assign pb_level[i]   = level_q;
        assign pb_press[i]   = press_q;
        assign pb_release[i] = release_q;

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
        localparam int            HW       = clog2(LONG_TICKS + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
        localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

        logic [HW-1:0] hold_cnt;
        logic          long_q;

        // Saturating at HOLD_MAX is what limits the pulse to once per press;
        // only a release (level back to 0) re-arms it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!level_q) begin
                    hold_cnt <= '0;
                end else if (tick && (hold_cnt != HOLD_MAX)) begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_cnt == HOLD_PRE) begin
                        long_q <= 1'b1;
                    end
                end
            end
        end

        assign pb_long[i] = long_q;
`else
        assign pb_long[i] = 1'b0;
`endif
    end

endmodule
